// File: rtl/reg_bus_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_initiator_if
//  Description : Command/response handshake and register-bus signals of the
//                SDMAC register-access initiator. The master modport is the
//                initiator's view; the slave modport is the view of whoever
//                issues commands and plays the responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_bus_initiator_if;
    // Command port
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    // Response port
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    // Register bus
    logic [7:0]  addr;
    logic        dmac_n;
    logic        as_n;
    logic        rw;
    logic [31:0] mod;
    logic [31:0] reg_od;
    logic        reg_dsk_n;

    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_data, reg_od, reg_dsk_n,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
               addr, dmac_n, as_n, rw, mod
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_data, reg_od, reg_dsk_n,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
               addr, dmac_n, as_n, rw, mod
    );
endinterface
`default_nettype wire

// File: rtl/reg_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_initiator
//  Description : Bus master for the SDMAC register protocol. Takes one
//                read/write command at a time, runs a DMAC_/AS_ register
//                cycle, waits for REG_DSK_ (or times out) and returns a
//                single-cycle response. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_initiator #(
    parameter int TIMEOUT  = 64,   // max WAIT cycles before abort (>=2)
    parameter int RECOVERY = 1     // idle cycles between bus cycles (>=1)
) (
    input  logic                clk,
    input  logic                rst_n,
    reg_bus_initiator_if.master bus
);

    localparam int CW  = $clog2(TIMEOUT);
    localparam int RCW = (RECOVERY > 1) ? $clog2(RECOVERY) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [RCW-1:0] REC_LAST = RCW'(RECOVERY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_WAIT    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t         state,     state_d;
    logic [CW-1:0]  cnt,       cnt_d;
    logic [RCW-1:0] rcnt,      rcnt_d;
    logic           cmd_ready, cmd_ready_d;
    logic           rsp_valid, rsp_valid_d;
    logic [31:0]    rsp_data,  rsp_data_d;
    logic           rsp_err,   rsp_err_d;
    logic           busy,      busy_d;
    logic [7:0]     addr,      addr_d;
    logic           dmac_n,    dmac_n_d;
    logic           as_n,      as_n_d;
    logic           rw,        rw_d;
    logic [31:0]    mod,       mod_d;

    // Next-state and next-output logic; every register holds unless a state says otherwise
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        rcnt_d      = rcnt;
        cmd_ready_d = cmd_ready;
        rsp_valid_d = 1'b0;          // response is a one-cycle pulse
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        busy_d      = busy;
        addr_d      = addr;
        dmac_n_d    = dmac_n;
        as_n_d      = as_n;
        rw_d        = rw;
        mod_d       = mod;

        case (state)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    addr_d      = bus.cmd_addr;
                    rw_d        = bus.cmd_rw;
                    mod_d       = bus.cmd_rw ? 32'h0 : bus.cmd_data;
                    dmac_n_d    = 1'b0;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                // Chip select has settled for a cycle; now strobe the address
                as_n_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.reg_dsk_n) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = rw ? bus.reg_od : 32'h0;
                    as_n_d      = 1'b1;
                    dmac_n_d    = 1'b1;
                    rcnt_d      = '0;
                    state_d     = S_RECOVER;
                end else if (cnt == CNT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = 32'h0;
                    as_n_d      = 1'b1;
                    dmac_n_d    = 1'b1;
                    rcnt_d      = '0;
                    state_d     = S_RECOVER;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_RECOVER: begin
                // Strobes stay negated for RECOVERY cycles before the next accept
                if (rcnt == REC_LAST) begin
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    rcnt_d = rcnt + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any cycle in flight without a response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rcnt      <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            addr      <= 8'h0;
            dmac_n    <= 1'b1;
            as_n      <= 1'b1;
            rw        <= 1'b1;
            mod       <= 32'h0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            rcnt      <= rcnt_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            busy      <= busy_d;
            addr      <= addr_d;
            dmac_n    <= dmac_n_d;
            as_n      <= as_n_d;
            rw        <= rw_d;
            mod       <= mod_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_err   = rsp_err;
    assign bus.busy      = busy;
    assign bus.addr      = addr;
    assign bus.dmac_n    = dmac_n;
    assign bus.as_n      = as_n;
    assign bus.rw        = rw;
    assign bus.mod       = mod;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_bus_initiator
//  Description : Self-checking bench for reg_bus_initiator. Commands push
//                their expected response into a queue; a monitor pops and
//                compares on every RSP_VALID. A behavioural responder
//                terminates each bus cycle after a programmable delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bus_initiator;

    localparam int TIMEOUT  = 64;
    localparam int RECOVERY = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Clock generation
    always #5 clk = ~clk;

    reg_bus_initiator_if bus ();

    reg_bus_initiator #(
        .TIMEOUT  (TIMEOUT),
        .RECOVERY (RECOVERY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [32:0] exp_q[$];          // {err, data}
    logic [32:0] mon_e;

    // Responder configuration: resp_delay = extra high WAIT edges, -1 = never terminate
    int          resp_delay = 0;
    logic [31:0] resp_od    = 32'h0;
    logic        idle_dsk   = 1'b1;
    int          as_cnt     = 0;

    // Expected bus contents while AS_ is low
    logic [7:0]  exp_addr = 8'h0;
    logic        exp_rw   = 1'b1;
    logic [31:0] exp_mod  = 32'h0;

    // Monitor bookkeeping
    int          as_low_run   = 0;
    int          as_high_run  = 0;
    int          last_as_len  = 0;
    int          min_high_gap = 1000;
    bit          gap_track    = 1'b0;
    bit          acc_rec      = 1'b0;
    int          acc_q[$];
    int          last_rsp_cyc = 0;
    int          accept_cyc   = 0;

    // Cycle counter (value seen after a posedge is the number of that edge)
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.reg_od = resp_od;

    // Responder: terminate resp_delay+1 edges after AS_ falls, otherwise follow idle_dsk
    always @(negedge clk) begin
        if (bus.as_n == 1'b0) begin
            as_cnt = as_cnt + 1;
            bus.reg_dsk_n = (resp_delay >= 0 && as_cnt > resp_delay) ? 1'b0 : 1'b1;
        end else begin
            as_cnt = 0;
            bus.reg_dsk_n = idle_dsk;
        end
    end

    // Monitor: scoreboard pop on responses, bus-content checks, strobe run lengths
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp got err=%b data=%h required no response",
                         bus.rsp_err, bus.rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.rsp_err, bus.rsp_data} !== mon_e) begin
                    errors++;
                    $display("FAIL rsp got err=%b data=%h required err=%b data=%h",
                             bus.rsp_err, bus.rsp_data, mon_e[32], mon_e[31:0]);
                end
            end
            last_rsp_cyc = cyc;
        end
        if (rst_n && acc_rec && bus.cmd_valid && bus.cmd_ready)
            acc_q.push_back(cyc + 1);
        if (bus.as_n == 1'b0) begin
            if (as_low_run == 0 && gap_track && as_high_run < min_high_gap)
                min_high_gap = as_high_run;
            as_high_run = 0;
            as_low_run++;
            checks++;
            if ({bus.dmac_n, bus.rw, bus.addr, bus.mod} !== {1'b0, exp_rw, exp_addr, exp_mod}) begin
                errors++;
                $display("FAIL bus_while_as got dmac_n=%b rw=%b addr=%h mod=%h required dmac_n=0 rw=%b addr=%h mod=%h",
                         bus.dmac_n, bus.rw, bus.addr, bus.mod, exp_rw, exp_addr, exp_mod);
            end
        end else begin
            if (as_low_run > 0) last_as_len = as_low_run;
            as_low_run = 0;
            as_high_run++;
        end
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", nm, got, req);
        end
    endtask

    // Full output bundle compared against the reset values
    task automatic chk_reset(input string nm);
        chk(nm, {49'h0, bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.busy,
                 bus.addr, bus.dmac_n, bus.as_n, bus.rw, bus.mod},
                {49'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b1, 1'b1, 1'b1, 32'h0});
    endtask

    // Issue one command; called and returns at posedge+1
    task automatic do_cmd(input logic rw, input logic [7:0] a, input logic [31:0] d,
                          input bit push, input logic [32:0] exp);
        int n = 0;
        while (!bus.cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout got 0 required 1");
        end
        exp_addr = a;
        exp_rw   = rw;
        exp_mod  = rw ? 32'h0 : d;
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = rw;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        accept_cyc    = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    // Wait for all expected responses and return to IDLE; called and returns at posedge+1
    task automatic wait_done(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0 || bus.busy) begin
            checks++;
            errors++;
            $display("FAIL %s_done got pending=%0d busy=%b required 0/0", nm, exp_q.size(), bus.busy);
            exp_q.delete();
        end
    endtask

    // Watchdog
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got no finish required finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = 1'b1;
        bus.cmd_addr  = 8'h0;
        bus.cmd_data  = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #2 chk_reset("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write, responder terminates after 3 AS_-low cycles
        resp_delay = 2;
        do_cmd(1'b0, 8'h08, 32'h0000_0104, 1'b1, {1'b0, 32'h0});
        wait_done("write");
        chk("write_as_len", 128'(last_as_len), 128'd3);
        chk("write_hold", {88'h0, bus.addr, bus.rw, bus.mod}, {88'h0, 8'h08, 1'b0, 32'h104});

        // Read, zero-wait responder
        resp_delay = 0;
        resp_od    = 32'h0000_0155;
        do_cmd(1'b1, 8'h1C, 32'hDEAD_BEEF, 1'b1, {1'b0, 32'h155});
        wait_done("read");
        chk("read_latency", 128'(last_rsp_cyc - accept_cyc), 128'd2);
        chk("read_as_len", 128'(last_as_len), 128'd1);

        // Timeout with REG_DSK_ held high
        resp_delay = -1;
        resp_od    = 32'hFFFF_FFFF;
        do_cmd(1'b1, 8'h20, 32'h0, 1'b1, {1'b1, 32'h0});
        wait_done("timeout");
        chk("timeout_as_len", 128'(last_as_len), 128'(TIMEOUT));
        chk("timeout_latency", 128'(last_rsp_cyc - accept_cyc), 128'(TIMEOUT + 1));
        chk("timeout_strobes", {126'h0, bus.dmac_n, bus.as_n}, {126'h0, 2'b11});

        // REG_DSK_ low in IDLE and SETUP only: must still time out
        idle_dsk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_cmd(1'b0, 8'h10, 32'h0000_1234, 1'b1, {1'b1, 32'h0});
        wait_done("early_dsk");
        chk("early_dsk_as_len", 128'(last_as_len), 128'(TIMEOUT));
        idle_dsk = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset two cycles into WAIT: no response for the aborted command
        resp_delay = -1;
        do_cmd(1'b1, 8'h30, 32'h0, 1'b0, 33'h0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("async_reset");
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Normal command after reset
        resp_delay = 1;
        resp_od    = 32'h0000_0777;
        do_cmd(1'b1, 8'h30, 32'h0, 1'b1, {1'b0, 32'h777});
        wait_done("post_reset");
        chk("post_reset_as_len", 128'(last_as_len), 128'd2);

        // Back-to-back reads with CMD_VALID held high
        resp_delay   = 0;
        resp_od      = 32'h0000_0ABC;
        exp_addr     = 8'h04;
        exp_rw       = 1'b1;
        exp_mod      = 32'h0;
        acc_q.delete();
        min_high_gap = 1000;
        gap_track    = 1'b1;
        acc_rec      = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 32'h0000_0ABC});
        bus.cmd_rw    = 1'b1;
        bus.cmd_addr  = 8'h04;
        bus.cmd_data  = 32'h5555_AAAA;
        bus.cmd_valid = 1'b1;
        begin
            int n = 0;
            while (acc_q.size() < 4 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
        end
        bus.cmd_valid = 1'b0;
        acc_rec       = 1'b0;
        wait_done("b2b");
        gap_track = 1'b0;
        chk("b2b_accepts", 128'(acc_q.size()), 128'd4);
        for (int i = 0; i + 1 < acc_q.size(); i++)
            chk("b2b_interval", 128'(acc_q[i+1] - acc_q[i]), 128'(3 + RECOVERY));
        checks++;
        if (min_high_gap < 2) begin
            errors++;
            $display("FAIL b2b_as_gap got %0d required >=2", min_high_gap);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
